serial_mod_detector: RTL and testbench
======================================

Name: serial_mod_detector

Overview:
- Parametrised serial divisibility/remainder tracker, the next generation of the fixed divide-by-5 serial detector.
- Accepts a framed bit stream, one bit per valid cycle, in either MSB-first or LSB-first order, and keeps the running value mod DIVISOR.
- Reports the final remainder and a divisible flag per frame.
- Sits between a serial bit source and downstream control logic that needs per-frame divisibility checks.

Parameters:
- DIVISOR, 5, modulus; integer >= 2.
- CNT_W, 8, width of the frame bit counter.
- REM_W, clog2(DIVISOR), remainder width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a new frame; clears remainder, weight and count; samples lsb_first.
- lsb_first  input  1  frame bit order, sampled only when start=1 (0 = MSB-first, 1 = LSB-first).
- bit_valid  input  1  bit_in is presented this cycle.
- bit_in  input  1  serial data bit.
- last  input  1  qualifies the final bit of the frame; meaningful only with bit_valid=1.
- rem  output  REM_W  registered running remainder of the current frame.
- div_now  output  1  registered; 1 when rem==0 and the frame has accepted at least one bit.
- done  output  1  one-cycle pulse when a frame completes.
- result_rem  output  REM_W  remainder of the last completed frame; held until the next done.
- result_div  output  1  1 when result_rem==0; held with result_rem.
- bit_count  output  CNT_W  bits accepted in the current frame; saturates.
- overflow  output  1  sticky per frame; set when bit_count saturates and another bit is accepted.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; rem=0, div_now=0, done=0, result_rem=0, result_div=0, bit_count=0, overflow=0, internal weight=1, mode=0.
- Reset mid-frame discards the frame; no done pulse is produced.
- States:
  - IDLE: bit_valid is ignored unless start=1.
  - RUN: bits are accepted.
- IDLE -> RUN on start. RUN -> IDLE on an accepted bit with last=1. RUN -> RUN (restart) on start.
- A bit is accepted in a cycle when (state==RUN or start==1) and bit_valid==1.
- When start=1, the remainder base is 0 and the weight base is 1 for that cycle. A bit accepted with start is the first bit of the new frame; any in-flight frame is aborted with no done pulse.
- MSB-first update: rem' = (2*rem + bit_in) mod DIVISOR.
- LSB-first update: rem' = (rem + bit_in*w) mod DIVISOR; w' = (2*w) mod DIVISOR.
- Arithmetic is done at REM_W+1 bits with a single conditional subtract of DIVISOR. No division operator.
- All updates take effect at the accepting edge: 0-cycle latency from the presented bit to the registered rem.
- div_now' = (rem'==0) on each accepted bit. div_now is cleared by start without bit_valid.
- bit_count increments per accepted bit and saturates at 2^CNT_W-1. An accepted bit while saturated sets overflow. The remainder stays exact regardless of overflow.
- On an accepted bit with last=1:
  - done=1 for exactly the next cycle;
  - result_rem=rem'; result_div=(rem'==0);
  - state returns to IDLE;
  - rem, div_now, bit_count and overflow hold their values until the next start.
- last without bit_valid is ignored.
- start with bit_valid=1 and last=1 forms a one-bit frame: done pulses and result_rem = bit_in mod DIVISOR.
- bit_valid=0 cycles in RUN hold all state (gaps are allowed).
- start without bit_valid: rem=0, bit_count=0, overflow=0, w=1, state=RUN.

Test Plan:
- DIVISOR=5, MSB-first bits 1,0,1,0 (value 10), last on the 4th bit -> rem sequence 1,2,0,0; done one cycle; result_rem=0, result_div=1, bit_count=4.
- DIVISOR=5, LSB-first bits 1,0,1,1 (value 13) with a bit_valid gap after bit 2 -> rem sequence 1,1,(hold),0,3; result_rem=3, result_div=0.
- DIVISOR=7, MSB-first 0xFF (8 ones) -> result_rem=3, result_div=0. Also 0xFC (252) -> result_rem=0, result_div=1.
- Frame of 3 bits, then start with bit_valid=1 bit_in=1 -> no done for the aborted frame; rem=1, bit_count=1. Finishing with bits 1,1 (MSB value 7, DIVISOR=5) -> result_rem=2.
- rst_n asserted asynchronously mid-frame (between edges) -> all outputs 0 immediately; subsequent bit_valid without start is ignored (rem stays 0, no done).
- CNT_W=2, 5-bit frame -> bit_count saturates at 3, overflow=1, result_rem still exact. One-bit frame (start+bit_valid+last, bit_in=1) -> done, result_rem=1.

Source files
------------

// File: rtl/serial_mod_detector.sv
// rtl/serial_mod_detector.sv - framed serial bit stream remainder/divisibility tracker
module serial_mod_detector #(
    parameter  int DIVISOR = 5,
    parameter  int CNT_W   = 8,
    localparam int REM_W   = $clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             lsb_first,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             last,
    output logic [REM_W-1:0] rem,
    output logic             div_now,
    output logic             done,
    output logic [REM_W-1:0] result_rem,
    output logic             result_div,
    output logic [CNT_W-1:0] bit_count,
    output logic             overflow
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [REM_W:0]   DIV_X  = (REM_W+1)'(DIVISOR);
    localparam logic [REM_W-1:0] W_ONE  = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [REM_W-1:0] w;
    logic             mode;

    logic             accept;
    logic             use_lsb;
    logic [REM_W-1:0] base_rem;
    logic [REM_W-1:0] base_w;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [REM_W:0]   sum;
    logic [REM_W:0]   sum_red;
    logic [REM_W:0]   dbl;
    logic [REM_W:0]   dbl_red;
    logic [REM_W-1:0] next_rem;
    logic [REM_W-1:0] next_w;

    // A start cycle rebases the arithmetic so a bit arriving with start is bit 0 of the new frame.
    always_comb begin
        accept   = ((state == RUN) || start) && bit_valid;
        use_lsb  = start ? lsb_first : mode;
        base_rem = start ? '0 : rem;
        base_w   = start ? W_ONE : w;
        base_cnt = start ? '0 : bit_count;
        base_ovf = start ? 1'b0 : overflow;

        if (use_lsb) begin
            sum = {1'b0, base_rem} + (bit_in ? {1'b0, base_w} : '0);
        end else begin
            sum = {base_rem, bit_in};
        end
        sum_red  = (sum >= DIV_X) ? (sum - DIV_X) : sum;
        next_rem = sum_red[REM_W-1:0];

        dbl      = {base_w, 1'b0};
        dbl_red  = (dbl >= DIV_X) ? (dbl - DIV_X) : dbl;
        next_w   = dbl_red[REM_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            w          <= W_ONE;
            mode       <= 1'b0;
            div_now    <= 1'b0;
            done       <= 1'b0;
            result_rem <= '0;
            result_div <= 1'b0;
            bit_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                rem     <= next_rem;
                w       <= use_lsb ? next_w : base_w;
                mode    <= use_lsb;
                div_now <= (next_rem == '0);
                if (base_cnt == CNT_MAX) begin
                    bit_count <= base_cnt;
                    overflow  <= 1'b1;
                end else begin
                    bit_count <= base_cnt + 1'b1;
                    overflow  <= base_ovf;
                end
                if (last) begin
                    done       <= 1'b1;
                    result_rem <= next_rem;
                    result_div <= (next_rem == '0);
                    state      <= IDLE;
                end else begin
                    state <= RUN;
                end
            end else if (start) begin
                rem       <= '0;
                w         <= W_ONE;
                mode      <= lsb_first;
                div_now   <= 1'b0;
                bit_count <= '0;
                overflow  <= 1'b0;
                state     <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_serial_mod_detector.sv
// tb/tb_serial_mod_detector.sv - scoreboard bench for serial_mod_detector (D=5, D=7, D=5 with 2-bit counter)
module tb_serial_mod_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, lsb_first = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, last = 1'b0;

    logic [2:0] d5_rem, d5_rrem, d7_rem, d7_rrem, s5_rem, s5_rrem;
    logic       d5_div, d5_done, d5_rdiv, d5_ovf;
    logic       d7_div, d7_done, d7_rdiv, d7_ovf;
    logic       s5_div, s5_done, s5_rdiv, s5_ovf;
    logic [7:0] d5_cnt, d7_cnt;
    logic [1:0] s5_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int r;
        int d;
        int c;
        int o;
    } exp_t;

    exp_t q5[$];
    exp_t q7[$];
    exp_t qs[$];

    always #5 clk = ~clk;

    serial_mod_detector #(.DIVISOR(5), .CNT_W(8)) u_d5 (
        .clk(clk), .rst_n(rst_n), .start(start), .lsb_first(lsb_first), .bit_valid(bit_valid),
        .bit_in(bit_in), .last(last), .rem(d5_rem), .div_now(d5_div), .done(d5_done),
        .result_rem(d5_rrem), .result_div(d5_rdiv), .bit_count(d5_cnt), .overflow(d5_ovf)
    );

    serial_mod_detector #(.DIVISOR(7), .CNT_W(8)) u_d7 (
        .clk(clk), .rst_n(rst_n), .start(start), .lsb_first(lsb_first), .bit_valid(bit_valid),
        .bit_in(bit_in), .last(last), .rem(d7_rem), .div_now(d7_div), .done(d7_done),
        .result_rem(d7_rrem), .result_div(d7_rdiv), .bit_count(d7_cnt), .overflow(d7_ovf)
    );

    serial_mod_detector #(.DIVISOR(5), .CNT_W(2)) u_s5 (
        .clk(clk), .rst_n(rst_n), .start(start), .lsb_first(lsb_first), .bit_valid(bit_valid),
        .bit_in(bit_in), .last(last), .rem(s5_rem), .div_now(s5_div), .done(s5_done),
        .result_rem(s5_rrem), .result_div(s5_rdiv), .bit_count(s5_cnt), .overflow(s5_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected frame results derived from the integer value of the frame.
    task automatic push_expect(input int v, input int n);
        q5.push_back('{r: v % 5, d: (v % 5 == 0) ? 1 : 0, c: (n > 255) ? 255 : n, o: (n > 255) ? 1 : 0});
        q7.push_back('{r: v % 7, d: (v % 7 == 0) ? 1 : 0, c: (n > 255) ? 255 : n, o: (n > 255) ? 1 : 0});
        qs.push_back('{r: v % 5, d: (v % 5 == 0) ? 1 : 0, c: (n > 3) ? 3 : n, o: (n > 3) ? 1 : 0});
    endtask

    task automatic drive(input logic st, input logic lsbf, input logic bv, input logic b, input logic lst);
        start = st; lsb_first = lsbf; bit_valid = bv; bit_in = b; last = lst;
        @(posedge clk);
        #1;
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; last = 1'b0;
    endtask

    // Sends the low n bits of val in the chosen order; a finished frame gets its expectation queued.
    task automatic frame(input logic lsbf, input int n, input logic [7:0] val, input bit bit_start, input bit fin);
        logic [7:0] v;
        v = val;
        if (fin) push_expect(int'(v), n);
        if (!bit_start) drive(1'b1, lsbf, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            drive((i == 0) && bit_start, lsbf, 1'b1, lsbf ? v[i] : v[n-1-i], fin && (i == n - 1));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (d5_done) begin
                if (q5.size() == 0) check("d5 unexpected done", 1, 0);
                else begin
                    exp_t e;
                    e = q5.pop_front();
                    check("d5 result_rem", d5_rrem, e.r);
                    check("d5 result_div", d5_rdiv, e.d);
                    check("d5 bit_count", d5_cnt, e.c);
                    check("d5 overflow", d5_ovf, e.o);
                end
            end
            if (d7_done) begin
                if (q7.size() == 0) check("d7 unexpected done", 1, 0);
                else begin
                    exp_t e;
                    e = q7.pop_front();
                    check("d7 result_rem", d7_rrem, e.r);
                    check("d7 result_div", d7_rdiv, e.d);
                    check("d7 bit_count", d7_cnt, e.c);
                    check("d7 overflow", d7_ovf, e.o);
                end
            end
            if (s5_done) begin
                if (qs.size() == 0) check("s5 unexpected done", 1, 0);
                else begin
                    exp_t e;
                    e = qs.pop_front();
                    check("s5 result_rem", s5_rrem, e.r);
                    check("s5 result_div", s5_rdiv, e.d);
                    check("s5 bit_count", s5_cnt, e.c);
                    check("s5 overflow", s5_ovf, e.o);
                end
            end
        end
    end

    initial begin
        #1;
        check("reset d5 rem", d5_rem, 0);
        check("reset d5 flags", {d5_div, d5_done, d5_rdiv, d5_ovf}, 0);
        check("reset d5 result/count", {d5_rrem, d5_cnt}, 0);
        check("reset d7/s5 outputs", |{d7_rem, d7_div, d7_done, d7_rrem, d7_rdiv, d7_cnt, d7_ovf,
                                       s5_rem, s5_div, s5_done, s5_rrem, s5_rdiv, s5_cnt, s5_ovf}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // MSB-first 1,0,1,0 = 10
        push_expect(10, 4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t1 start rem", d5_rem, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1 rem b1", d5_rem, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t1 rem b2", d5_rem, 2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1 rem b3", d5_rem, 0);
        check("t1 div_now b3", d5_div, 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t1 rem b4", d5_rem, 0);
        check("t1 done", d5_done, 1);
        check("t1 result_div", d5_rdiv, 1);
        check("t1 bit_count", d5_cnt, 4);
        @(posedge clk); #1;
        check("t1 done one cycle", d5_done, 0);
        check("t1 count held", d5_cnt, 4);

        // LSB-first 1,0,1,1 = 13 with a gap after the second bit
        push_expect(13, 4);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t2 rem b1", d5_rem, 1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2 rem b2", d5_rem, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("t2 rem gap", d5_rem, 1);
        check("t2 count gap", d5_cnt, 2);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t2 rem b3", d5_rem, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t2 rem b4", d5_rem, 3);
        check("t2 result_rem", d5_rrem, 3);
        check("t2 result_div", d5_rdiv, 0);

        // 0xFF and 0xFC MSB-first
        frame(1'b0, 8, 8'hFF, 1'b0, 1'b1);
        check("t3 d7 0xFF rem", d7_rrem, 3);
        frame(1'b0, 8, 8'hFC, 1'b1, 1'b1);
        check("t3 d7 0xFC rem", d7_rrem, 0);
        check("t3 d7 0xFC div", d7_rdiv, 1);

        // Abort a 3-bit frame with start+bit, then finish 1,1,1 = 7
        frame(1'b0, 3, 8'b101, 1'b1, 1'b0);
        push_expect(7, 3);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t4 restart rem", d5_rem, 1);
        check("t4 restart count", d5_cnt, 1);
        check("t4 no done", d5_done, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t4 result_rem", d5_rrem, 2);

        // Asynchronous reset mid-frame
        frame(1'b0, 2, 8'b11, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("t5 reset rem", d5_rem, 0);
        check("t5 reset result", {d5_rrem, d5_rdiv}, 0);
        check("t5 reset count", {d5_cnt, d5_ovf, d5_div, d5_done}, 0);
        #2 rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t5 ignored rem", d5_rem, 0);
        check("t5 ignored count", d5_cnt, 0);
        check("t5 ignored done", d5_done, 0);

        // Saturation on the 2-bit counter: 1,0,1,1,1 = 23
        frame(1'b0, 5, 8'b10111, 1'b1, 1'b1);
        check("t6 s5 count", s5_cnt, 3);
        check("t6 s5 overflow", s5_ovf, 1);
        check("t6 s5 result_rem", s5_rrem, 3);
        check("t6 d5 count", d5_cnt, 5);

        // One-bit frames
        push_expect(1, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t7 one-bit done", d5_done, 1);
        check("t7 one-bit rem", d5_rrem, 1);
        push_expect(0, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t7 zero-bit div", d5_rdiv, 1);

        repeat (3) @(posedge clk);
        #1;
        check("d5 pending frames", q5.size(), 0);
        check("d7 pending frames", q7.size(), 0);
        check("s5 pending frames", qs.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
